// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free preg IDs feeding the RAT.
// Define FREE_LIST_DBL_FREE_CHECK_EN to add in-list tracking and the dbl_free_err port.
module free_list #(
  parameter int NUM_PREGS    = 64,
  parameter int NUM_AREGS    = 32,
  parameter int RENAME_WIDTH = 2,
  parameter int PW           = $clog2(NUM_PREGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RENAME_WIDTH-1:0]    alloc_req,
  output logic                       alloc_ok,
  output logic [PW*RENAME_WIDTH-1:0] alloc_preg,
  input  logic [RENAME_WIDTH-1:0]    rel_valid,
  input  logic [PW*RENAME_WIDTH-1:0] rel_preg,
  output logic [PW:0]                free_count,
  output logic                       overflow_err
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
  ,
  output logic                       dbl_free_err
`endif
);
  localparam int NFREE0 = NUM_PREGS - NUM_AREGS;
  localparam logic [PW:0] CNT1    = (PW+1)'(1);
  localparam logic [PW:0] NPREG_C = (PW+1)'(NUM_PREGS);
  localparam logic [PW:0] CNT_RST = (PW+1)'(NFREE0);

  function automatic logic [NUM_PREGS-1:0][PW-1:0] init_mem();
    logic [NUM_PREGS-1:0][PW-1:0] m;
    m = '0;
    for (int i = 0; i < NFREE0; i++) m[i] = PW'(i + NUM_AREGS);
    return m;
  endfunction
  localparam logic [NUM_PREGS-1:0][PW-1:0] MEM_RST = init_mem();

  logic [NUM_PREGS-1:0][PW-1:0] r_mem, w_mem_nxt;
  logic [PW-1:0]                r_head, r_tail;
  logic [PW:0]                  r_count;
  logic                         r_ovf;

  logic [PW:0]                  w_need, w_grant, w_space, w_acc;
  logic [PW-1:0]                w_aoff, w_rp, w_widx;
  logic [RENAME_WIDTH-1:0][PW-1:0] w_aidx;
  logic                         w_drop, w_ok;

`ifdef FREE_LIST_DBL_FREE_CHECK_EN
  localparam logic [NUM_PREGS-1:0] INL_RST = {NUM_PREGS{1'b1}} << NUM_AREGS;
  logic [NUM_PREGS-1:0] r_inlist, w_inl_nxt, w_seen;
  logic                 r_dbl, w_dbl;
  assign dbl_free_err = r_dbl;
`endif

  assign free_count   = r_count;
  assign overflow_err = r_ovf;

  // Allocation: requesting lanes are compacted onto consecutive head entries.
  always_comb begin
    w_need     = '0;
    w_aoff     = '0;
    w_aidx     = '0;
    alloc_preg = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      w_aidx[k] = r_head + w_aoff;
      if (alloc_req[k]) begin
        alloc_preg[k*PW +: PW] = r_mem[w_aidx[k]];
        w_aoff = w_aoff + PW'(1);
        w_need = w_need + CNT1;
      end
    end
    alloc_ok = (r_count >= w_need);
    w_grant  = alloc_ok ? w_need : '0;
  end

  // Release: capacity accounts for this cycle's granted allocations.
  always_comb begin
    w_space   = NPREG_C - (r_count - w_grant);
    w_acc     = '0;
    w_drop    = 1'b0;
    w_ok      = 1'b0;
    w_rp      = '0;
    w_widx    = '0;
    w_mem_nxt = r_mem;
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
    w_seen    = r_inlist;
    w_inl_nxt = r_inlist;
    w_dbl     = 1'b0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      if (alloc_ok && alloc_req[k]) begin
        if (!r_inlist[alloc_preg[k*PW +: PW]]) w_dbl = 1'b1;
        w_inl_nxt[alloc_preg[k*PW +: PW]] = 1'b0;
      end
    end
`endif
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      w_rp = rel_preg[k*PW +: PW];
      w_ok = rel_valid[k];
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
      // Already free, or repeated by an earlier lane this cycle.
      if (w_ok && w_seen[w_rp]) begin
        w_ok  = 1'b0;
        w_dbl = 1'b1;
      end
      if (w_ok) w_seen[w_rp] = 1'b1;
`endif
      if (w_ok) begin
        if (w_acc < w_space) begin
          w_widx            = r_tail + w_acc[PW-1:0];
          w_mem_nxt[w_widx] = w_rp;
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
          w_inl_nxt[w_rp]   = 1'b1;
`endif
          w_acc = w_acc + CNT1;
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem   <= MEM_RST;
      r_head  <= '0;
      r_tail  <= PW'(NFREE0);
      r_count <= CNT_RST;
      r_ovf   <= 1'b0;
    end else begin
      r_mem   <= w_mem_nxt;
      r_head  <= r_head + w_grant[PW-1:0];
      r_tail  <= r_tail + w_acc[PW-1:0];
      r_count <= r_count - w_grant + w_acc;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

`ifdef FREE_LIST_DBL_FREE_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inlist <= INL_RST;
      r_dbl    <= 1'b0;
    end else begin
      r_inlist <= w_inl_nxt;
      if (w_dbl) r_dbl <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the documented scenarios.
module tb_free_list;
  localparam int NP = 64, NA = 32, RW = 2, PW = 6;

  logic            clk = 1'b0, rst = 1'b0;
  logic [RW-1:0]   alloc_req = '0, rel_valid = '0;
  logic [PW*RW-1:0] rel_preg = '0;
  logic            alloc_ok;
  logic [PW*RW-1:0] alloc_preg;
  logic [PW:0]     free_count;
  logic            overflow_err;
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
  logic            dbl_free_err;
`endif

  int n_vec = 0, n_err = 0;
  int q[$];
  bit m_ovf, m_dbl;
  bit chk_en = 1'b0;

  free_list #(.NUM_PREGS(NP), .NUM_AREGS(NA), .RENAME_WIDTH(RW), .PW(PW)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_ok(alloc_ok), .alloc_preg(alloc_preg),
    .rel_valid(rel_valid), .rel_preg(rel_preg),
    .free_count(free_count), .overflow_err(overflow_err)
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
    , .dbl_free_err(dbl_free_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    q.delete();
    for (int i = NA; i < NP; i++) q.push_back(i);
    m_ovf = 1'b0;
    m_dbl = 1'b0;
  endtask

  // Reference model: list contents as a queue, updated at each edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else begin
      int need, p;
      int snap[$];
      bit dup;
      need = $countones(alloc_req);
      snap = q;
      if (q.size() >= need) repeat (need) void'(q.pop_front());
      for (int k = 0; k < RW; k++) begin
        if (rel_valid[k]) begin
          p = int'(rel_preg[k*PW +: PW]);
          dup = 1'b0;
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
          foreach (snap[j]) if (snap[j] == p) dup = 1'b1;
          if (dup) m_dbl = 1'b1;
          else snap.push_back(p);
`endif
          if (!dup) begin
            if (q.size() < NP) q.push_back(p);
            else m_ovf = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int need, off;
      need = $countones(alloc_req);
      off  = 0;
      chk("alloc_ok", {31'd0, alloc_ok}, (q.size() >= need) ? 1 : 0);
      for (int k = 0; k < RW; k++) begin
        if (alloc_req[k]) begin
          if (q.size() >= need) chk($sformatf("alloc_preg[%0d]", k), alloc_preg[k*PW +: PW], q[off]);
          off++;
        end else begin
          chk($sformatf("idle_lane[%0d]", k), alloc_preg[k*PW +: PW], 0);
        end
      end
      chk("free_count", free_count, q.size());
      chk("overflow_err", {31'd0, overflow_err}, m_ovf);
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
      chk("dbl_free_err", {31'd0, dbl_free_err}, m_dbl);
`endif
    end
  end

  task automatic step(input logic [RW-1:0] req, input logic [RW-1:0] rv, input int p0, input int p1);
    alloc_req = req;
    rel_valid = rv;
    rel_preg  = {PW'(p1), PW'(p0)};
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alloc_req = '0;
    rel_valid = '0;
    rst = 1'b0;
    nxt();
    nxt();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    chk_en = 1'b1;
    do_reset();

    // Reset image and first grouped allocation
    step(2'b00, 2'b00, 0, 0);
    chk("rst_free_count", free_count, 32);
    chk("rst_overflow", {31'd0, overflow_err}, 0);
    chk("idle_alloc_ok", {31'd0, alloc_ok}, 1);
    nxt();
    step(2'b11, 2'b00, 0, 0);
    chk("t1_ok", {31'd0, alloc_ok}, 1);
    chk("t1_lane0", alloc_preg[5:0], 32);
    chk("t1_lane1", alloc_preg[11:6], 33);
    nxt();
    step(2'b00, 2'b00, 0, 0);
    chk("t1_count", free_count, 30);
    nxt();

    // Compacted allocation
    do_reset();
    step(2'b10, 2'b00, 0, 0);
    chk("t2_ok", {31'd0, alloc_ok}, 1);
    chk("t2_lane1", alloc_preg[11:6], 32);
    chk("t2_lane0", alloc_preg[5:0], 0);
    nxt();
    step(2'b01, 2'b00, 0, 0);
    chk("t2b_lane0", alloc_preg[5:0], 33);
    nxt();

    // Drain to empty, stall, release-to-allocate latency
    do_reset();
    repeat (16) begin step(2'b11, 2'b00, 0, 0); nxt(); end
    step(2'b01, 2'b01, 40, 0);
    chk("t3_empty", free_count, 0);
    chk("t3_stall", {31'd0, alloc_ok}, 0);
    nxt();
    step(2'b01, 2'b00, 0, 0);
    chk("t3_ok", {31'd0, alloc_ok}, 1);
    chk("t3_lane0", alloc_preg[5:0], 40);
    nxt();

    // Same-cycle releases do not satisfy allocations
    step(2'b00, 2'b01, 50, 0);
    nxt();
    step(2'b11, 2'b11, 5, 6);
    chk("t4_count1", free_count, 1);
    chk("t4_stall", {31'd0, alloc_ok}, 0);
    nxt();
    step(2'b11, 2'b00, 0, 0);
    chk("t4_count3", free_count, 3);
    chk("t4_lane0", alloc_preg[5:0], 50);
    chk("t4_lane1", alloc_preg[11:6], 5);
    nxt();
    step(2'b01, 2'b00, 0, 0);
    chk("t4_last", alloc_preg[5:0], 6);
    nxt();

    // Tail wraps 63->0 within one release group
    do_reset();
    repeat (16) begin step(2'b11, 2'b00, 0, 0); nxt(); end
    for (int i = 0; i < 15; i++) begin step(2'b00, 2'b11, 32 + 2*i, 33 + 2*i); nxt(); end
    step(2'b00, 2'b01, 62, 0); nxt();
    step(2'b00, 2'b11, 7, 9); nxt();
    step(2'b00, 2'b00, 0, 0);
    chk("t5_count", free_count, 33);
    nxt();
    repeat (15) begin step(2'b11, 2'b00, 0, 0); nxt(); end
    step(2'b01, 2'b00, 0, 0); nxt();
    step(2'b11, 2'b00, 0, 0);
    chk("t5_lane0", alloc_preg[5:0], 7);
    chk("t5_lane1", alloc_preg[11:6], 9);
    nxt();

    // Fill to capacity, then overflow
    do_reset();
    for (int i = 0; i < 16; i++) begin step(2'b00, 2'b11, 2*i, 2*i + 1); nxt(); end
    step(2'b00, 2'b01, 33, 0);
    chk("t6_full", free_count, 64);
    nxt();
    step(2'b00, 2'b00, 0, 0);
    chk("t6_still_full", free_count, 64);
`ifndef FREE_LIST_DBL_FREE_CHECK_EN
    chk("t6_overflow", {31'd0, overflow_err}, 1);
`endif
    nxt();
    step(2'b11, 2'b00, 0, 0);
    chk("t6_head_lane0", alloc_preg[5:0], 32);
    nxt();

    // Reset mid-operation clears sticky state
    do_reset();
    step(2'b00, 2'b00, 0, 0);
    chk("t7_overflow_clr", {31'd0, overflow_err}, 0);
    chk("t7_count", free_count, 32);
    nxt();

`ifdef FREE_LIST_DBL_FREE_CHECK_EN
    step(2'b00, 2'b01, 40, 0); nxt();
    step(2'b00, 2'b00, 0, 0);
    chk("t8_dbl", {31'd0, dbl_free_err}, 1);
    chk("t8_count", free_count, 32);
    nxt();
    do_reset();
    step(2'b00, 2'b11, 3, 3); nxt();
    step(2'b00, 2'b00, 0, 0);
    chk("t8_dup_count", free_count, 33);
    nxt();
`endif

    alloc_req = '0;
    rel_valid = '0;
    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
